// File: rtl/multi_debouncer.sv
// Multi-channel pushbutton debouncer with per-channel synchroniser,
// stability filter, press/release pulses and a long-press pulse.
module multi_debouncer #(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_button,
    output logic [NUM_CH-1:0] o_state,
    output logic [NUM_CH-1:0] o_press,
    output logic [NUM_CH-1:0] o_release,
    output logic [NUM_CH-1:0] o_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LG_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LG_LAST = LW'(LONG_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
    logic [DW-1:0]          stab_q [NUM_CH];
    logic [DW-1:0]          stab_d [NUM_CH];
    logic [LW-1:0]          long_q [NUM_CH];
    logic [LW-1:0]          long_d [NUM_CH];

    logic [NUM_CH-1:0] sync_out;
    logic [NUM_CH-1:0] state_q, state_d;
    logic [NUM_CH-1:0] press_q, press_d;
    logic [NUM_CH-1:0] rel_q, rel_d;
    logic [NUM_CH-1:0] lpulse_q, lpulse_d;

    always_comb begin
        sync_out = '0;
        state_d  = state_q;
        press_d  = '0;
        rel_d    = '0;
        lpulse_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sync_d[c]   = {sync_q[c][SYNC_STAGES-2:0], i_button[c]};
            sync_out[c] = sync_q[c][SYNC_STAGES-1] ^ POL;
            stab_d[c]   = '0;
            if (sync_out[c] != state_q[c]) begin
                if (stab_q[c] == DB_MAX) begin
                    state_d[c] = sync_out[c];
                end else begin
                    stab_d[c] = stab_q[c] + 1'b1;
                end
            end
            press_d[c] = state_d[c] & ~state_q[c];
            rel_d[c]   = ~state_d[c] & state_q[c];
            // Long count runs on held cycles; a release on the final cycle suppresses the pulse.
            long_d[c] = '0;
            if (state_q[c]) begin
                long_d[c]   = (long_q[c] == LG_MAX) ? long_q[c] : long_q[c] + 1'b1;
                lpulse_d[c] = state_d[c] & (long_q[c] == LG_LAST);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sync_q[c] <= {SYNC_STAGES{POL}};
                stab_q[c] <= '0;
                long_q[c] <= '0;
            end
            state_q  <= '0;
            press_q  <= '0;
            rel_q    <= '0;
            lpulse_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                sync_q[c] <= sync_d[c];
                stab_q[c] <= stab_d[c];
                long_q[c] <= long_d[c];
            end
            state_q  <= state_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            lpulse_q <= lpulse_d;
        end
    end

    assign o_state   = state_q;
    assign o_press   = press_q;
    assign o_release = rel_q;
    assign o_long    = lpulse_q;

endmodule
